// File: rtl/bm_pkg.sv
// ---------------------------------------------------------------------------
// bm_pkg
// Shared definitions for the bit manipulation sequencer and its single-step
// BitManipulation unit.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   OP_* / DIR_*  : encodings of the op_rotate and direction controls
//   DEFAULT_WIDTH : default operand width
// ---------------------------------------------------------------------------
package bm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_SHIFT  = 1'b0;
  localparam logic OP_ROTATE = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_manip_sequencer_step.sv
// ---------------------------------------------------------------------------
// BitManipulation
// Single-step combinational shift/rotate unit. It moves the operand by
// exactly one bit position and reports the bit that left (or wrapped around).
// Ports:
//   data_in       in  WIDTH  operand
//   enable_shift  in  1      perform a logical shift (zero fill)
//   enable_rotate in  1      perform a rotate
//   shift_dir     in  1      shift direction (0 = left, 1 = right)
//   rotate_dir    in  1      rotate direction (0 = left, 1 = right)
//   data_out      out WIDTH  stepped operand (passes data_in through if idle)
//   carry         out 1      bit shifted out / wrapped; 0 if no op enabled
// ---------------------------------------------------------------------------
module BitManipulation
  import bm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable_shift,
  input  logic             enable_rotate,
  input  logic             shift_dir,
  input  logic             rotate_dir,
  output logic [WIDTH-1:0] data_out,
  output logic             carry
);

  // Shift takes priority over rotate if both enables are ever set at once.
  always_comb begin
    data_out = data_in;
    carry    = 1'b0;
    if (enable_shift) begin
      if (shift_dir == DIR_LEFT) begin
        {carry, data_out} = {data_in, 1'b0};
      end else begin
        {data_out, carry} = {1'b0, data_in};
      end
    end else if (enable_rotate) begin
      if (rotate_dir == DIR_LEFT) begin
        data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
        carry    = data_in[WIDTH-1];
      end else begin
        data_out = {data_in[0], data_in[WIDTH-1:1]};
        carry    = data_in[0];
      end
    end
  end

endmodule

// File: rtl/bit_manip_sequencer.sv
// ---------------------------------------------------------------------------
// bit_manip_sequencer
// Multi-cycle controller that shifts or rotates an operand by 0..WIDTH-1
// positions, one position per clock, using the BitManipulation step unit.
// Optional feature macro: BIT_MANIP_SEQ_ZERO_FLAG_EN (adds the zero output).
// Ports:
//   clk        in  1      system clock, rising edge
//   rst_n      in  1      synchronous active-low reset
//   start      in  1      request, sampled only in IDLE
//   op_rotate  in  1      0 = logical shift, 1 = rotate
//   direction  in  1      0 = left, 1 = right
//   amount     in  AMT_W  number of single-bit steps
//   data_in    in  WIDTH  operand, latched with start
//   busy       out 1      high whenever not IDLE
//   done       out 1      one-cycle result-valid pulse
//   data_out   out WIDTH  working register (intermediate values during RUN)
//   carry      out 1      bit moved out / wrapped on the final step
//   zero       out 1      result == 0 (only with BIT_MANIP_SEQ_ZERO_FLAG_EN)
// ---------------------------------------------------------------------------
module bit_manip_sequencer
  import bm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_rotate,
  input  logic             direction,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  if (AMT_W != $clog2(WIDTH)) begin : g_bad_amt_w
    $error("bit_manip_sequencer: AMT_W must equal clog2(WIDTH)");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] cnt;
  logic             carry_r;
  logic             op_rotate_r;
  logic             direction_r;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // The step unit always looks at the work register; its result is only
  // committed while in RUN.
  BitManipulation #(.WIDTH(WIDTH)) u_step (
    .data_in      (work),
    .enable_shift (op_rotate_r == OP_SHIFT),
    .enable_rotate(op_rotate_r == OP_ROTATE),
    .shift_dir    (direction_r),
    .rotate_dir   (direction_r),
    .data_out     (step_data),
    .carry        (step_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero amount skips RUN entirely; the last RUN step is the one taken
  // with cnt == 1. DONE always falls back to IDLE, ignoring start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (amount == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/control capture on an accepted start, then one step per RUN
  // cycle. Nothing changes in DONE, so the result is held into IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work        <= '0;
      cnt         <= '0;
      carry_r     <= 1'b0;
      op_rotate_r <= 1'b0;
      direction_r <= 1'b0;
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
      zero        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work        <= data_in;
            cnt         <= amount;
            carry_r     <= 1'b0;
            op_rotate_r <= op_rotate;
            direction_r <= direction;
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
            zero        <= (data_in == '0);
`endif
          end
        end
        RUN: begin
          work    <= step_data;
          carry_r <= step_carry;
          cnt     <= cnt - AMT_W'(1);
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
          zero    <= (step_data == '0);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign data_out = work;
  assign carry    = carry_r;

endmodule

// File: tb/tb_bit_manip_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bit_manip_sequencer
// Scoreboard bench for bit_manip_sequencer. Each accepted request pushes the
// expected result (computed from whole-amount arithmetic) into a queue; a
// monitor pops and compares whenever done is high.
// Optional feature macro: BIT_MANIP_SEQ_ZERO_FLAG_EN (checks zero as well).
// ---------------------------------------------------------------------------
module tb_bit_manip_sequencer;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op_rotate = 1'b0;
  logic       direction = 1'b0;
  logic [2:0] amount = '0;
  logic [7:0] data_in = '0;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic       carry;
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
  logic       zero;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  bit_manip_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_rotate(op_rotate),
    .direction(direction),
    .amount   (amount),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .carry    (carry)
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the whole operation as one arithmetic shift/rotate by n.
  function automatic exp_t model(input logic [7:0] d, input logic rot,
                                 input logic dir, input int n);
    int   v;
    int   r;
    int   c;
    exp_t e;
    v = int'(d);
    if (n == 0) begin
      r = v;
      c = 0;
    end else if (!rot && !dir) begin
      r = (v << n) & 255;
      c = (v >> (8 - n)) & 1;
    end else if (!rot && dir) begin
      r = v >> n;
      c = (v >> (n - 1)) & 1;
    end else if (rot && !dir) begin
      r = ((v << n) | (v >> (8 - n))) & 255;
      c = r & 1;
    end else begin
      r = ((v >> n) | (v << (8 - n))) & 255;
      c = (r >> 7) & 1;
    end
    e.data  = 8'(r);
    e.carry = (c != 0);
    e.zero  = (r == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("data_out", int'(data_out), int'(e.data));
        checkOutput("carry", int'(carry), int'(e.carry));
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
        checkOutput("zero", int'(zero), int'(e.zero));
`endif
      end
    end
  end

  // Issue one request from IDLE, push its expectation, then wait for done
  // while throwing ignored starts with junk operands at the busy block.
  task automatic applyStimulus(input logic [7:0] d, input logic rot,
                               input logic dir, input int n, input bit noise);
    int cycles;
    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);
    start     = 1'b1;
    data_in   = d;
    op_rotate = rot;
    direction = dir;
    amount    = 3'(n);
    sb.push_back(model(d, rot, dir, n));
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 20) begin
      checkOutput("busy_run", int'(busy), 1);
      if (noise) begin
        start     = 1'($urandom_range(0, 1));
        data_in   = 8'($urandom);
        op_rotate = 1'($urandom);
        direction = 1'($urandom);
        amount    = 3'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("latency", cycles, n);
    checkOutput("busy_done", int'(busy), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    exp_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_data", int'(data_out), 0);
      checkOutput("rst_carry", int'(carry), 0);
    end

    // Directed cases.
    applyStimulus(8'hB4, 1'b0, 1'b0, 3, 1'b0);
    applyStimulus(8'hB4, 1'b1, 1'b1, 4, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b1, 7, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0, 7, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0, 7, 1'b0);
    applyStimulus(8'h5A, 1'b0, 1'b0, 0, 1'b0);

    // Start during the DONE cycle must be ignored.
    start     = 1'b1;
    data_in   = 8'h33;
    amount    = 3'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_start_busy", int'(busy), 0);
    checkOutput("done_start_done", int'(done), 0);
    checkOutput("done_start_hold", int'(data_out), 'h5A);

    // Reset in the middle of a run: no done, everything cleared.
    @(negedge clk);
    start     = 1'b1;
    data_in   = 8'h0C;
    op_rotate = 1'b0;
    direction = 1'b0;
    amount    = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'h77;
    amount  = 3'd2;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_data", int'(data_out), 0);
    checkOutput("midrst_carry", int'(carry), 0);
`ifdef BIT_MANIP_SEQ_ZERO_FLAG_EN
    checkOutput("midrst_zero", int'(zero), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(8'h0C, 1'b0, 1'b0, 5, 1'b0);

    // Randomized requests with junk starts while busy.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 7)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    cycles = 0;
    while (sb.size() != 0 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_manip_sequencer.md
Name: bit_manip_sequencer

Overview:
- Multi-cycle controller that shifts or rotates an 8-bit operand by 0..7 positions, one position per clock.
- Drives the single-step combinational BitManipulation unit in the multiprocessor datapath and consumes its output.
- Accepts a start pulse, iterates, then returns the result and the last carry with a one-cycle done pulse.
- Sits between the instruction/operand registers and the register-file writeback path.

Parameters:
- WIDTH, 8, operand width in bits.
- AMT_W, 3, width of amount; must equal clog2(WIDTH); elaboration error otherwise.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_rotate  in  1  0 = logical shift, 1 = rotate (no carry-in).
- direction  in  1  0 = left, 1 = right.
- amount  in  AMT_W  number of single-bit steps, 0..WIDTH-1.
- data_in  in  WIDTH  operand; latched together with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result is valid.
- data_out  out  WIDTH  working register; valid while done is high, then held until the next accepted start.
- carry  out  1  bit moved out or wrapped on the final step; 0 when amount = 0.
- zero  out  1  present only with ZERO_FLAG_EN.

Behaviour:
- Reset: rst_n low at a rising edge puts the block in IDLE and clears all outputs (busy, done, data_out, carry, zero) and all internal registers. This holds in any state, including mid-RUN; the in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE with start = 1 at edge k:
  - Latch data_in into the work register and latch op_rotate, direction and amount.
  - Clear carry.
  - amount = 0: next state DONE; data_out = data_in.
  - amount > 0: next state RUN; cnt = amount.
- RUN, each edge:
  - work <= step(work); carry <= step carry; cnt <= cnt - 1.
  - When cnt = 1 at the edge, next state is DONE.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally. A start asserted during DONE is ignored.
- Latency: done is high in the cycle between edges k+N and k+N+1, where N = amount. Total occupancy is N+1 cycles.
- Start while busy is ignored, with no queueing. Input changes after the latch have no effect.
- Step function, one position:
  - Shift left: out = {w[W-2:0], 0}; carry = w[W-1].
  - Shift right: out = {0, w[W-1:1]}; carry = w[0].
  - Rotate left: out = {w[W-2:0], w[W-1]}; carry = w[W-1].
  - Rotate right: out = {w[0], w[W-1:1]}; carry = w[0].
- data_out is combinationally the work register. It shows intermediate values during RUN, which consumers must ignore.

Optional Feature:
- Macro: BIT_MANIP_SEQ_ZERO_FLAG_EN.
- When defined: the zero output exists. It is registered and updated on the same edge as each work update; zero = (next work == 0). Reset value is 0. It is valid while done is high and held with data_out.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package bm_pkg holds:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - op encoding constants (OP_SHIFT = 0, OP_ROTATE = 1, DIR_LEFT = 0, DIR_RIGHT = 1);
  - default WIDTH = 8.
- One sub-module: the existing BitManipulation single-step unit, instantiated on the work register.
  - enable_shift = ~op_rotate and enable_rotate = op_rotate.
  - Both direction inputs are driven by direction.
  - Its data_out and carry feed the work and carry registers.

Test Plan:
- Reset, then rst_n = 1 idle for 5 cycles -> busy = 0, done = 0, data_out = 0x00, carry = 0 throughout.
- data_in = 0xB4, shift left, amount = 3 -> done after edge k+3; data_out = 0xA0, carry = 1; busy high for 4 cycles.
- data_in = 0xB4, rotate right, amount = 4 -> data_out = 0x4B, carry = 0. Then data_in = 0xFF, shift right, amount = 7 -> data_out = 0x01, carry = 1.
- data_in = 0x5A, amount = 0 -> done in the cycle right after edge k; data_out = 0x5A, carry = 0. A start pulse during that done cycle is ignored; the block returns to IDLE.
- Start shift left amount = 5 on 0x0C; assert a second start with different data at k+2; pull rst_n low at k+3 -> no done ever; outputs zero after reset. The next start runs normally.
- With BIT_MANIP_SEQ_ZERO_FLAG_EN: data_in = 0x02, shift left, amount = 7 -> data_out = 0x00, carry = 1, zero = 1. Data_in = 0x01, rotate left, amount = 7 -> data_out = 0x80, zero = 0.
